// File: rtl/output_port_arbiter.sv
// Output port arbiter: selects one input buffer per cycle into a single-entry output register.
// Round-robin priority when ARB_ROUND_ROBIN_EN is defined, otherwise fixed priority (index 0 highest).
module output_port_arbiter #(
  parameter int DATA_W  = 64,
  parameter int NUM_REQ = 3,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arb_en,
  input  logic [NUM_REQ*DATA_W-1:0] req_di,
  input  logic [NUM_REQ-1:0]        req_si,
  output logic [NUM_REQ-1:0]        req_ri,
  input  logic                      out_ro,
  output logic                      out_so,
  output logic [DATA_W-1:0]         out_do,
  output logic [ID_W-1:0]           out_id
);

  logic              full;
  logic [DATA_W-1:0] data_reg;
  logic [ID_W-1:0]   id_reg;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic              any;
  logic              can_accept;
  logic              drain;
  logic              xfer;

  // Reset also masks the handshake so nothing leaves or enters while it is held.
  assign out_so     = full && arb_en && !reset;
  assign out_do     = data_reg;
  assign out_id     = id_reg;
  assign drain      = out_so && out_ro;
  assign can_accept = arb_en && !reset && (!full || out_ro);
  assign xfer       = any && can_accept;

  always_comb begin : scan
    int idx;
    idx = 0;
    any = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req_si[idx]) begin
        any = 1'b1;
        win = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ri = '0;
    if (xfer) req_ri[win] = 1'b1;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      if (win == ID_W'(NUM_REQ - 1)) ptr <= '0;
      else                           ptr <= win + 1'b1;
    end
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 1'b0;
      data_reg <= '0;
      id_reg   <= '0;
    end else if (xfer) begin
      full     <= 1'b1;
      data_reg <= req_di[win*DATA_W +: DATA_W];
      id_reg   <= win;
    end else if (drain) begin
      full     <= 1'b0;
    end
  end

endmodule
